// File: rtl/shapool_ram_pkg.sv
// Shared constants and the dump FSM state type for the round-constant RAM dump path.
package shapool_ram_pkg;

  // SB_RAM40_4K READ/WRITE_MODE encoding for 256x16 organisation
  localparam logic [1:0]  RAM_MODE_256X16 = 2'd0;
  localparam logic [7:0]  KT_BASE_ADDR    = 8'h80;
  localparam int unsigned KT_WORDS        = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DONE_ST = 2'd2
  } dump_state_e;

endpackage

// File: rtl/ram_dump_sequencer_if.sv
// RAM read port plus the valid/ready word stream of the dump sequencer.
interface ram_dump_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] mem_raddr;
  logic                  mem_re;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  word_valid;
  logic                  word_ready;
  logic [DATA_WIDTH-1:0] word_data;
  logic                  word_last;

  modport master (
    output mem_raddr, mem_re, word_valid, word_data, word_last,
    input  mem_rdata, word_ready
  );

  modport slave (
    input  mem_raddr, mem_re, word_valid, word_data, word_last,
    output mem_rdata, word_ready
  );
endinterface

// File: rtl/ram_dump_checksum.sv
// Modular sum of streamed words; cleared at dump start, accumulates on each transfer.
module ram_dump_checksum #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_clear,
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_sum
);
  logic [DATA_WIDTH-1:0] r_sum;

  always_ff @(posedge clk) begin
    if (reset || i_clear) r_sum <= '0;
    else if (i_en)        r_sum <= r_sum + i_data;
  end

  assign o_sum = r_sum;
endmodule

// File: rtl/ram_dump_sequencer.sv
// Dumps WORD_COUNT words from a synchronous RAM onto a valid/ready stream and a shift window.
// Optional running checksum port when DUMP_CHECKSUM_EN is defined.
module ram_dump_sequencer
  import shapool_ram_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter int unsigned           ADDR_WIDTH   = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = ADDR_WIDTH'(KT_BASE_ADDR),
  parameter int unsigned           WORD_COUNT   = KT_WORDS,
  parameter int unsigned           RESULT_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  ram_dump_sequencer_if.master    bus,
  output logic [RESULT_WIDTH-1:0] result
`ifdef DUMP_CHECKSUM_EN
  , output logic [DATA_WIDTH-1:0] checksum
`endif
);
  localparam int unsigned      CNT_W    = $clog2(WORD_COUNT + 1);
  localparam logic [CNT_W-1:0] N_WORDS  = CNT_W'(WORD_COUNT);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_COUNT - 1);

  if (WORD_COUNT == 0 ||
      (longint'(BASE_ADDR) + longint'(WORD_COUNT)) > (longint'(1) << ADDR_WIDTH)) begin : g_bad_range
    $error("ram_dump_sequencer: WORD_COUNT must be >=1 and the dump must fit below 2**ADDR_WIDTH");
  end
  if (RESULT_WIDTH < DATA_WIDTH || (RESULT_WIDTH % DATA_WIDTH) != 0) begin : g_bad_result
    $error("ram_dump_sequencer: RESULT_WIDTH must be a multiple of DATA_WIDTH");
  end

  dump_state_e           r_state, w_state_nxt;
  logic                  r_busy, r_done, r_valid;
  logic [ADDR_WIDTH-1:0] r_raddr;
  logic [CNT_W-1:0]      r_issued, r_xfer;
  logic [RESULT_WIDTH-1:0] r_result, w_result_shift;
  logic                  w_start, w_issue, w_xfer, w_last_xfer;

  assign w_start     = start && !r_busy;
  assign w_xfer      = r_valid && bus.word_ready;
  // A read is only issued when the word it produces has somewhere to go
  assign w_issue     = r_busy && (r_issued < N_WORDS) && (!r_valid || bus.word_ready);
  assign w_last_xfer = w_xfer && (r_xfer == LAST_IDX);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == RUN);
      r_done  <= (w_state_nxt == DONE_ST);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE_ST: if (start)       w_state_nxt = RUN;
      RUN:           if (w_last_xfer) w_state_nxt = DONE_ST;
      default:                        w_state_nxt = IDLE;
    endcase
  end

  if (RESULT_WIDTH == DATA_WIDTH) begin : g_res_single
    assign w_result_shift = bus.mem_rdata;
  end else begin : g_res_shift
    assign w_result_shift = {bus.mem_rdata, r_result[RESULT_WIDTH-1:DATA_WIDTH]};
  end

  always_ff @(posedge clk) begin
    if (reset || w_start) begin
      r_raddr  <= BASE_ADDR;
      r_issued <= '0;
      r_xfer   <= '0;
      r_valid  <= 1'b0;
      r_result <= '0;
    end else begin
      if (w_issue) begin
        r_issued <= r_issued + CNT_W'(1);
        // Hold on the final address so the top of memory never wraps to zero
        if (r_issued != LAST_IDX) r_raddr <= r_raddr + ADDR_WIDTH'(1);
      end
      if (w_issue)     r_valid <= 1'b1;
      else if (w_xfer) r_valid <= 1'b0;
      if (w_xfer) begin
        r_xfer   <= r_xfer + CNT_W'(1);
        r_result <= w_result_shift;
      end
    end
  end

`ifdef DUMP_CHECKSUM_EN
  ram_dump_checksum #(.DATA_WIDTH(DATA_WIDTH)) u_checksum (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_start),
    .i_en    (w_xfer),
    .i_data  (bus.mem_rdata),
    .o_sum   (checksum)
  );
`endif

  assign bus.mem_raddr  = r_raddr;
  assign bus.mem_re     = w_issue;
  assign bus.word_valid = r_valid;
  assign bus.word_data  = bus.mem_rdata;
  assign bus.word_last  = r_valid && (r_xfer == LAST_IDX);
  assign busy           = r_busy;
  assign done           = r_done;
  assign result         = r_result;

endmodule

// File: tb/tb_ram_dump_sequencer.sv
// Directed bench for ram_dump_sequencer: default 64-word dump and a 1-word dump at the top address.
module tb_ram_dump_sequencer;
  import shapool_ram_pkg::*;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 8;
  localparam int unsigned RW    = 64;
  localparam int          NW    = 64;
  localparam int          BOUND = 2000;

  typedef struct {
    int             mode;
    int             exp_words;
    logic [DW-1:0]  exp_first;
    logic [DW-1:0]  exp_last;
    logic [RW-1:0]  exp_result;
    int             exp_last_edge;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0, start1 = 1'b0, ready = 1'b0, ready1 = 1'b0;
  logic busy, done, busy1, done1;
  logic [RW-1:0] result, result1;
  logic [DW-1:0] rdata = 32'hDEAD_BEEF, rdata1 = 32'hDEAD_BEEF;
`ifdef DUMP_CHECKSUM_EN
  logic [DW-1:0] checksum, checksum1;
`endif

  int total = 0, bad = 0;
  int nx, last_e, seq_err, stall_err;
  logic [DW-1:0] first_w, last_w;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] ram_word(input logic [7:0] a);
    return {8'h00, a, 8'h01, a};
  endfunction

  ram_dump_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus  ();
  ram_dump_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();

  assign bus.mem_rdata   = rdata;
  assign bus.word_ready  = ready;
  assign bus1.mem_rdata  = rdata1;
  assign bus1.word_ready = ready1;

  // Paired 256x16 blocks: hi[a]=a, lo[a]=0x0100+a, one-cycle read latency
  always @(posedge clk) if (bus.mem_re)  rdata  <= ram_word(bus.mem_raddr);
  always @(posedge clk) if (bus1.mem_re) rdata1 <= ram_word(bus1.mem_raddr);

  ram_dump_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(8'h80),
                       .WORD_COUNT(NW), .RESULT_WIDTH(RW)) u_dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .bus(bus), .result(result)
`ifdef DUMP_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  ram_dump_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(8'hff),
                       .WORD_COUNT(1), .RESULT_WIDTH(RW)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1),
    .bus(bus1), .result(result1)
`ifdef DUMP_CHECKSUM_EN
    , .checksum(checksum1)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // One full dump on u_dut; mode 0 ready=1, 1 ready toggling, 2 random stalls
  task automatic run_dump(input int mode, input bit hold_start);
    logic [DW-1:0] held;
    bit stalled;
    nx = 0; last_e = -1; seq_err = 0; stall_err = 0;
    first_w = '0; last_w = '0; held = '0; stalled = 1'b0;
    @(negedge clk); start = 1'b1; ready = 1'b1;
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_done_clr", 64'(done), 64'd0);
    chk("start_addr", 64'(bus.mem_raddr), 64'h80);
    for (int k = 1; k < BOUND && nx < NW; k++) begin
      if (k > 1) @(negedge clk);
      case (mode)
        0:       ready = 1'b1;
        1:       ready = k[0];
        default: ready = ($urandom_range(0, 2) != 0);
      endcase
      #1;
      if (k == 1 && bus.word_valid) seq_err++;
      if (!bus.word_valid && bus.word_last) seq_err++;
      if (stalled && bus.word_data !== held) stall_err++;
      if (bus.word_valid && !ready && bus.mem_re) stall_err++;
      if (bus.word_valid && ready) begin
        if (bus.word_data !== ram_word(8'(8'h80 + nx))) seq_err++;
        if (bus.word_last !== (nx == NW - 1)) seq_err++;
        if (nx == 0) first_w = bus.word_data;
        last_w  = bus.word_data;
        last_e  = k;
        stalled = 1'b0;
        nx++;
      end else if (bus.word_valid) begin
        stalled = 1'b1;
        held    = bus.word_data;
      end else begin
        stalled = 1'b0;
      end
      if (nx == NW) start = 1'b0;
    end
    start = 1'b0;
    @(negedge clk);
    chk("end_done", 64'(done), 64'd1);
    chk("end_busy", 64'(busy), 64'd0);
    chk("end_valid", 64'(bus.word_valid), 64'd0);
  endtask

  initial begin
    vec_t vecs[3];
    bit   hit;
    vecs[0] = '{0, NW, 32'h0080_0180, 32'h00bf_01bf, 64'h00bf01bf_00be01be, 65};
    vecs[1] = '{1, NW, 32'h0080_0180, 32'h00bf_01bf, 64'h00bf01bf_00be01be, -1};
    vecs[2] = '{2, NW, 32'h0080_0180, 32'h00bf_01bf, 64'h00bf01bf_00be01be, -1};

    repeat (3) @(negedge clk);
    chk("rst_busy",   64'(busy), 64'd0);
    chk("rst_done",   64'(done), 64'd0);
    chk("rst_valid",  64'(bus.word_valid), 64'd0);
    chk("rst_re",     64'(bus.mem_re), 64'd0);
    chk("rst_addr",   64'(bus.mem_raddr), 64'h80);
    chk("rst_result", result, 64'd0);
    chk("rst_addr1",  64'(bus1.mem_raddr), 64'hff);
    reset = 1'b0;

    foreach (vecs[i]) begin
      run_dump(vecs[i].mode, 1'b0);
      chk($sformatf("v%0d_count", i),  64'(nx), 64'(vecs[i].exp_words));
      chk($sformatf("v%0d_first", i),  64'(first_w), 64'(vecs[i].exp_first));
      chk($sformatf("v%0d_last", i),   64'(last_w), 64'(vecs[i].exp_last));
      chk($sformatf("v%0d_result", i), result, vecs[i].exp_result);
      chk($sformatf("v%0d_seq", i),    64'(seq_err), 64'd0);
      chk($sformatf("v%0d_stall", i),  64'(stall_err), 64'd0);
      if (vecs[i].exp_last_edge >= 0)
        chk($sformatf("v%0d_last_edge", i), 64'(last_e), 64'(vecs[i].exp_last_edge));
`ifdef DUMP_CHECKSUM_EN
      chk($sformatf("v%0d_checksum", i), 64'(checksum), 64'h27E0_67E0);
`endif
    end

    // Reset while word 20 is on the stream aborts the dump at once
    @(negedge clk); start = 1'b1; ready = 1'b1;
    @(negedge clk); start = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < BOUND && !hit; k++) begin
      #1;
      if (bus.word_valid && bus.word_data == ram_word(8'h94)) hit = 1'b1;
      else @(negedge clk);
    end
    chk("abort_reach", 64'(hit), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy",  64'(busy), 64'd0);
    chk("abort_valid", 64'(bus.word_valid), 64'd0);
    chk("abort_re",    64'(bus.mem_re), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_idle_re",   64'(bus.mem_re), 64'd0);
    chk("abort_addr",      64'(bus.mem_raddr), 64'h80);
    chk("abort_result",    result, 64'd0);
    run_dump(0, 1'b0);
    chk("redump_first", 64'(first_w), 64'h0080_0180);
    chk("redump_count", 64'(nx), 64'(NW));
    chk("redump_seq",   64'(seq_err), 64'd0);

    // start held through the whole dump gives exactly one dump
    run_dump(0, 1'b1);
    chk("hold_count", 64'(nx), 64'(NW));
    chk("hold_seq",   64'(seq_err), 64'd0);
    repeat (3) @(negedge clk);
    chk("hold_still_done", 64'(done), 64'd1);
    chk("hold_no_restart", 64'(busy), 64'd0);
    run_dump(0, 1'b0);
    chk("again_count",  64'(nx), 64'(NW));
    chk("again_result", result, 64'h00bf01bf_00be01be);

    // Single-word dump from the top address
    @(negedge clk); start1 = 1'b1; ready1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    #1;
    chk("one_re",     64'(bus1.mem_re), 64'd1);
    chk("one_addr",   64'(bus1.mem_raddr), 64'hff);
    chk("one_novalid", 64'(bus1.word_valid), 64'd0);
    @(negedge clk); #1;
    chk("one_valid", 64'(bus1.word_valid), 64'd1);
    chk("one_last",  64'(bus1.word_last), 64'd1);
    chk("one_data",  64'(bus1.word_data), 64'h00ff_01ff);
    chk("one_nowrap", 64'(bus1.mem_raddr), 64'hff);
    chk("one_re_off", 64'(bus1.mem_re), 64'd0);
    @(negedge clk);
    chk("one_done",   64'(done1), 64'd1);
    chk("one_busy",   64'(busy1), 64'd0);
    chk("one_result", result1, 64'h00ff01ff_00000000);
    chk("one_addr_end", 64'(bus1.mem_raddr), 64'hff);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
